// File: rtl/uart_transmitter.sv
//==========================================================================
// Module : uart_transmitter
// Brief  : Pops FIFO words and sends them MSB-byte-first as 8N1 UART frames.
//          Define UART_TX_PARITY_EN for 8E1 frames (even parity bit).
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module uart_transmitter #(
  parameter int UART_BPS      = 'd9600,
  parameter int CLK_FREQ      = 'd50_000_000,
  parameter int FIFO_RD_WIDTH = 'd32,
  parameter int FIFO_RD_BYTE  = 'd4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  localparam int c_bit_cyc = CLK_FREQ / UART_BPS;
  localparam int c_cnt_w   = (c_bit_cyc > 1) ? $clog2(c_bit_cyc) : 1;
  localparam int c_byte_w  = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(c_bit_cyc - 1);
  localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(FIFO_RD_BYTE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [2:0]               r_bit;
  logic [c_byte_w-1:0]      r_byte;
  logic [FIFO_RD_WIDTH-1:0] r_word;
  logic                     r_tx;
  logic                     r_tx_done;
  logic                     w_tx_next;
  logic                     w_done_next;
  logic                     w_in_bit;
  logic                     w_bit_end;
  logic [7:0]               w_cur_byte;

  // The word register shifts left per byte, so the byte on the wire is always the top one.
  assign w_cur_byte = r_word[FIFO_RD_WIDTH-1 -: 8];
  assign w_in_bit   = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_bit_end  = (r_cnt == c_cnt_last);

  assign tx         = r_tx;
  assign tx_done    = r_tx_done;
  assign busy       = (r_state != S_IDLE);
  assign fifo_rd_en = (r_state == S_RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // tx is registered, so the line level is decided from the state being entered.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = 1'b1;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) w_state_next = S_RD;
      end
      S_RD: begin
        w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next = S_START;
        w_tx_next    = 1'b0;
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_tx_next    = w_cur_byte[0];
        end
      end
      S_DATA: begin
        w_tx_next = w_cur_byte[r_bit];
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = ^w_cur_byte;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_tx_next = w_cur_byte[r_bit + 3'd1];
          end
        end
      end
      S_PARITY: begin
        w_tx_next = ^w_cur_byte;
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte == c_byte_last) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_word    <= '0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx      <= w_tx_next;
      r_tx_done <= w_done_next;

      if (w_in_bit && !w_bit_end) r_cnt <= r_cnt + 1'b1;
      else                        r_cnt <= '0;

      if (r_state == S_DATA) begin
        if (w_bit_end) r_bit <= r_bit + 3'd1;
      end else begin
        r_bit <= '0;
      end

      if (r_state == S_LOAD) begin
        r_word <= fifo_rd_data;
        r_byte <= '0;
      end else if ((r_state == S_STOP) && w_bit_end && (r_byte != c_byte_last)) begin
        r_word <= r_word << 8;
        r_byte <= r_byte + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
